// File: rtl/req_pending_dispatcher_if.sv
// Request/grant bundle for req_pending_dispatcher.
// master drives requests and accepts grants; slave is the dispatcher.
interface req_pending_dispatcher_if #(
    parameter int N = 4
) ();
    localparam int IW = $clog2(N);

    logic [N-1:0]  req_i;
    logic [N-1:0]  mask_i;
    logic          gnt_valid;
    logic          gnt_ready;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  pend_o;
    logic [N-1:0]  ovf_o;
    logic          ovf_clr;
    logic          busy_o;

    modport master (
        output req_i, mask_i, gnt_ready, ovf_clr,
        input  gnt_valid, gnt_idx, pend_o, ovf_o, busy_o
    );

    modport slave (
        input  req_i, mask_i, gnt_ready, ovf_clr,
        output gnt_valid, gnt_idx, pend_o, ovf_o, busy_o
    );
endinterface

// File: rtl/req_pending_dispatcher.sv
// Sticky pending capture of request pulses with a registered,
// highest-index-first grant over a valid/ready handshake.
module req_pending_dispatcher #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic clk,
    input  logic rst_n,
    req_pending_dispatcher_if.slave bus
);
    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [N-1:0]  pend_q;
    logic [N-1:0]  ovf_q;
    logic [N-1:0]  set_vec;
    logic [N-1:0]  clr_vec;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] top_idx;
    logic          accept;
    logic          load;

    // Later iterations overwrite, so the highest set index wins.
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_q[i]) top_idx = IW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (|pend_q) state_d = OFFER;
            OFFER:   if (bus.gnt_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept  = (state_q == OFFER) && bus.gnt_ready;
        load    = (state_q == IDLE) && (|pend_q);
        set_vec = bus.req_i & bus.mask_i;
        clr_vec = accept ? (N'(1) << idx_q) : '0;
    end

    // A new event on the line being retired keeps it pending (set wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= '0;
            idx_q  <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_vec) | set_vec;
            ovf_q  <= (bus.ovf_clr ? '0 : ovf_q)
                    | (set_vec & pend_q & ~clr_vec);
            if (load) idx_q <= top_idx;
        end
    end

    assign bus.gnt_valid = (state_q == OFFER);
    assign bus.gnt_idx   = idx_q;
    assign bus.pend_o    = pend_q;
    assign bus.ovf_o     = ovf_q;
    assign bus.busy_o    = (|pend_q) | (state_q == OFFER);

endmodule
